// File: rtl/local_inject_sched_if.sv
// Requester-side and router-local-port bundle for local_inject_sched.
// master = requesters + router (drives flits and credit returns); slave = scheduler.
interface local_inject_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int VC_NUM  = 2,
    parameter int FLIT_W  = 32
) ();
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*FLIT_W-1:0] req_flit;
    logic [NUM_REQ-1:0]        req_ready;
    logic [FLIT_W-1:0]         local_tx;
    logic [VC_NUM-1:0]         local_vc_write_tx;
    logic [VC_NUM-1:0]         local_incr_rx_vec;
    logic                      err_credit;
    logic                      err_proto;

    modport master (
        output req_valid, req_flit, local_incr_rx_vec,
        input  req_ready, local_tx, local_vc_write_tx, err_credit, err_proto
    );

    modport slave (
        input  req_valid, req_flit, local_incr_rx_vec,
        output req_ready, local_tx, local_vc_write_tx, err_credit, err_proto
    );
endinterface

// File: rtl/local_inject_sched.sv
// Round-robin packet scheduler: NUM_REQ requesters share one credit-flow-controlled router local port.
// Latency 1 cycle accept->local_tx; req_ready follows registered credits, whole packets are never interleaved.
module local_inject_sched #(
    parameter int NUM_REQ  = 4,
    parameter int VC_NUM   = 2,
    parameter int VC_DEPTH = 4,
    parameter int FLIT_W   = 32
) (
    input logic                 clk,
    input logic                 rst,
    local_inject_sched_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int VC_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int CRD_W = $clog2(VC_DEPTH + 1);
    localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(VC_DEPTH);

    localparam logic [1:0] FT_HEAD   = 2'b01;
    localparam logic [1:0] FT_BODY   = 2'b00;
    localparam logic [1:0] FT_TAIL   = 2'b10;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [VC_W-1:0]    vc_q, vc_d;
    logic [CRD_W-1:0]   credit_q [VC_NUM];
    logic [CRD_W-1:0]   credit_d [VC_NUM];
    logic               credit_ovf;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   scan_idx;
    logic               free_found;
    logic [VC_W-1:0]    free_vc;

    logic [IDX_W-1:0]   sel;
    logic [FLIT_W-1:0]  sel_flit;
    logic [1:0]         ftype;
    logic [NUM_REQ-1:0] ready;
    logic               fwd;
    logic [VC_W-1:0]    fwd_vc;
    logic [VC_NUM-1:0]  wr_vec;
    logic               proto_err;

    logic [FLIT_W-1:0]  local_tx_q;
    logic [VC_NUM-1:0]  vc_write_q;
    logic               err_credit_q;
    logic               err_proto_q;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + IDX_W'(1);
    endfunction

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        scan_idx  = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && bus.req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
            scan_idx = next_idx(scan_idx);
        end
    end

    always_comb begin
        free_found = 1'b0;
        free_vc    = '0;
        for (int v = VC_NUM - 1; v >= 0; v--) begin
            if (credit_q[v] != '0) begin
                free_found = 1'b1;
                free_vc    = VC_W'(v);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        vc_d      = vc_q;
        rr_ptr_d  = rr_ptr_q;
        ready     = '0;
        fwd       = 1'b0;
        fwd_vc    = vc_q;
        proto_err = 1'b0;
        sel       = (state_q == IDLE) ? win_idx : owner_q;
        sel_flit  = bus.req_flit[int'(sel)*FLIT_W +: FLIT_W];
        ftype     = sel_flit[FLIT_W-1 -: 2];

        case (state_q)
            IDLE: begin
                if (win_found && free_found) begin
                    ready[win_idx] = 1'b1;
                    case (ftype)
                        FT_HEAD: begin
                            fwd     = 1'b1;
                            fwd_vc  = free_vc;
                            owner_d = win_idx;
                            vc_d    = free_vc;
                            state_d = SEND;
                        end
                        FT_SINGLE: begin
                            fwd      = 1'b1;
                            fwd_vc   = free_vc;
                            rr_ptr_d = next_idx(win_idx);
                        end
                        FT_BODY, FT_TAIL: proto_err = 1'b1;
                    endcase
                end
            end
            SEND: begin
                ready[owner_q] = (credit_q[vc_q] != '0);
                if (ready[owner_q] && bus.req_valid[owner_q]) begin
                    fwd    = 1'b1;
                    fwd_vc = vc_q;
                    if (ftype == FT_TAIL) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_idx(owner_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_vec = fwd ? (VC_NUM'(1) << fwd_vc) : '0;

    // A write and a return in the same cycle cancel; a return into a full counter is an overflow.
    always_comb begin
        credit_ovf = 1'b0;
        for (int v = 0; v < VC_NUM; v++) begin
            credit_d[v] = credit_q[v];
            if (wr_vec[v] && !bus.local_incr_rx_vec[v]) begin
                credit_d[v] = credit_q[v] - CRD_W'(1);
            end else if (!wr_vec[v] && bus.local_incr_rx_vec[v]) begin
                if (credit_q[v] == CRD_MAX) begin
                    credit_ovf = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + CRD_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            vc_q         <= '0;
            local_tx_q   <= '0;
            vc_write_q   <= '0;
            err_credit_q <= 1'b0;
            err_proto_q  <= 1'b0;
            for (int v = 0; v < VC_NUM; v++) begin
                credit_q[v] <= CRD_MAX;
            end
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            vc_q       <= vc_d;
            vc_write_q <= wr_vec;
            if (fwd) begin
                local_tx_q <= sel_flit;
            end
            if (credit_ovf) begin
                err_credit_q <= 1'b1;
            end
            if (proto_err) begin
                err_proto_q <= 1'b1;
            end
            for (int v = 0; v < VC_NUM; v++) begin
                credit_q[v] <= credit_d[v];
            end
        end
    end

    // Grants are held off while reset is low even though state is already at its reset value.
    assign bus.req_ready         = rst ? ready : '0;
    assign bus.local_tx          = local_tx_q;
    assign bus.local_vc_write_tx = vc_write_q;
    assign bus.err_credit        = err_credit_q;
    assign bus.err_proto         = err_proto_q;
endmodule

// File: tb/tb_local_inject_sched.sv
// Bench for local_inject_sched: directed scenarios with literal expectations plus a randomized run
// compared every cycle against a packet-level model of the scheduler.
module tb_local_inject_sched;
    localparam int NR    = 4;
    localparam int NV    = 2;
    localparam int DEPTH = 4;
    localparam int FW    = 32;

    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    local_inject_sched_if #(.NUM_REQ(NR), .VC_NUM(NV), .FLIT_W(FW)) bus ();

    local_inject_sched #(
        .NUM_REQ(NR), .VC_NUM(NV), .VC_DEPTH(DEPTH), .FLIT_W(FW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- packet-level model ----------------
    bit          m_open;
    int          m_owner, m_vc, m_rr;
    int          m_cred [NV];
    logic [FW-1:0] m_tx;
    logic [NV-1:0] m_vcw;
    bit          m_ec, m_ep;

    function automatic logic [FW-1:0] flit_of(input int i);
        return bus.req_flit[i*FW +: FW];
    endfunction

    function automatic int first_vc();
        for (int v = 0; v < NV; v++) if (m_cred[v] > 0) return v;
        return -1;
    endfunction

    function automatic logic [NR-1:0] model_ready();
        logic [NR-1:0] r;
        r = '0;
        if (!m_open) begin
            if (first_vc() >= 0) begin
                for (int k = 0; k < NR; k++) begin
                    int i;
                    i = (m_rr + k) % NR;
                    if (bus.req_valid[i]) begin
                        r[i] = 1'b1;
                        break;
                    end
                end
            end
        end else if (m_cred[m_vc] > 0) begin
            r[m_owner] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_step(input logic [NR-1:0] rdy);
        int who, wvc;
        bit fwd, d, inc;
        logic [FW-1:0] f;
        logic [1:0] t;
        fwd = 0; wvc = 0; who = -1; f = '0;
        for (int i = 0; i < NR; i++) if (rdy[i] && bus.req_valid[i]) who = i;
        if (who >= 0) begin
            f = flit_of(who);
            t = f[FW-1:FW-2];
            if (!m_open) begin
                wvc = first_vc();
                if (t == T_HEAD) begin
                    fwd = 1; m_open = 1; m_owner = who; m_vc = wvc;
                end else if (t == T_SINGLE) begin
                    fwd = 1; m_rr = (who + 1) % NR;
                end else begin
                    m_ep = 1;
                end
            end else begin
                fwd = 1; wvc = m_vc;
                if (t == T_TAIL) begin
                    m_open = 0; m_rr = (who + 1) % NR;
                end
            end
        end
        for (int v = 0; v < NV; v++) begin
            d   = fwd && (wvc == v);
            inc = bus.local_incr_rx_vec[v];
            if (d && !inc) m_cred[v]--;
            else if (!d && inc) begin
                if (m_cred[v] == DEPTH) m_ec = 1;
                else m_cred[v]++;
            end
        end
        m_vcw = '0;
        if (fwd) begin
            m_vcw[wvc] = 1'b1;
            m_tx = f;
        end
    endtask

    always @(negedge clk) begin
        logic [NR-1:0] exp_rdy;
        if (!rst) begin
            m_open = 0; m_owner = 0; m_vc = 0; m_rr = 0;
            for (int v = 0; v < NV; v++) m_cred[v] = DEPTH;
            m_tx = '0; m_vcw = '0; m_ec = 0; m_ep = 0;
            check("rst_req_ready", bus.req_ready, '0);
            check("rst_local_tx", bus.local_tx, '0);
            check("rst_vc_write", bus.local_vc_write_tx, '0);
            check("rst_errs", {bus.err_credit, bus.err_proto}, 2'b00);
        end else begin
            exp_rdy = model_ready();
            check("mdl_req_ready", bus.req_ready, exp_rdy);
            check("mdl_local_tx", bus.local_tx, m_tx);
            check("mdl_vc_write", bus.local_vc_write_tx, m_vcw);
            check("mdl_err_credit", bus.err_credit, m_ec);
            check("mdl_err_proto", bus.err_proto, m_ep);
            model_step(exp_rdy);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic [1:0] t, input logic [29:0] pay);
        bus.req_flit[i*FW +: FW] = {t, pay};
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b0;
        bus.req_valid = '0;
        bus.local_incr_rx_vec = '0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Random requester generators and router buffer occupancy.
    bit            has [NR];
    int            rem [NR];
    logic [FW-1:0] cur [NR];
    int            infl [NV];

    task automatic new_pkt(input int i);
        int len;
        if ($urandom % 20 == 0) begin
            cur[i] = {($urandom % 2 == 0) ? T_BODY : T_TAIL, 30'($urandom)};
            rem[i] = 0;
        end else begin
            len = $urandom_range(1, 5);
            cur[i] = {(len == 1) ? T_SINGLE : T_HEAD, 30'($urandom)};
            rem[i] = len - 1;
        end
        has[i] = 1;
    endtask

    task automatic advance(input int i);
        if (rem[i] > 0) begin
            rem[i]--;
            cur[i] = {(rem[i] == 0) ? T_TAIL : T_BODY, 30'($urandom)};
        end else begin
            has[i] = 0;
        end
    endtask

    task automatic clear_gen();
        for (int i = 0; i < NR; i++) begin has[i] = 0; rem[i] = 0; cur[i] = '0; end
        for (int v = 0; v < NV; v++) infl[v] = 0;
    endtask

    initial begin
        logic [7:0]    pat;
        int            sent;
        logic [NR-1:0] acc;

        bus.req_valid = '0;
        bus.req_flit = '0;
        bus.local_incr_rx_vec = '0;
        #2 rst = 1'b0;
        bus.req_valid = '1;
        #1 check("rst_ready_with_valid", bus.req_ready, 4'b0000);
        bus.req_valid = '0;

        // Single flit on requester 2 right after reset.
        do_reset();
        bus.req_valid = 4'b0100;
        put(2, T_SINGLE, 30'h123);
        #1 check("single_ready", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = '0;
        #1 check("single_tx", bus.local_tx, {T_SINGLE, 30'h123});
        check("single_vcw", bus.local_vc_write_tx, 2'b01);
        tick();
        #1 check("single_vcw_idle", bus.local_vc_write_tx, 2'b00);
        check("single_tx_hold", bus.local_tx, {T_SINGLE, 30'h123});

        // 6-flit packet against 4 credits, one credit returned in cycle 5.
        do_reset();
        pat = 8'b0100_1111;
        sent = 0;
        for (int c = 0; c < 8; c++) begin
            bus.req_valid = 4'b0001;
            put(0, (sent == 0) ? T_HEAD : ((sent == 5) ? T_TAIL : T_BODY), 30'(100 + sent));
            bus.local_incr_rx_vec = (c == 5) ? 2'b01 : 2'b00;
            #1 check($sformatf("credit_ready_c%0d", c), bus.req_ready[0], pat[c]);
            if (bus.req_ready[0]) sent++;
            tick();
        end
        check("credit_sent", sent, 5);
        check("credit_last_tx", bus.local_tx, {T_BODY, 30'd104});
        // Reset mid-packet.
        rst = 1'b0;
        #1 check("midrst_tx", bus.local_tx, '0);
        check("midrst_vcw", bus.local_vc_write_tx, 2'b00);
        check("midrst_ready", bus.req_ready, 4'b0000);
        tick();
        rst = 1'b1;
        bus.req_valid = 4'b0010;
        put(1, T_HEAD, 30'h1);
        #1 check("postrst_ready", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = '0;
        #1 check("postrst_vcw", bus.local_vc_write_tx, 2'b01);

        // Round-robin with two 2-flit packets, then VC0 exhausted.
        do_reset();
        bus.req_valid = 4'b0011;
        put(0, T_HEAD, 30'h10); put(1, T_HEAD, 30'h20);
        #1 check("rr_c0_ready", bus.req_ready, 4'b0001);
        tick();
        put(0, T_TAIL, 30'h11);
        #1 check("rr_c1_ready", bus.req_ready, 4'b0001);
        check("rr_c1_tx", bus.local_tx, {T_HEAD, 30'h10});
        tick();
        bus.req_valid = 4'b0010;
        #1 check("rr_c2_ready", bus.req_ready, 4'b0010);
        tick();
        put(1, T_TAIL, 30'h21);
        #1 check("rr_c3_ready", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = 4'b0101;
        put(0, T_HEAD, 30'h12); put(2, T_HEAD, 30'h30);
        #1 check("rr_c4_ready", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = 4'b0001;
        #1 check("vc1_vcw", bus.local_vc_write_tx, 2'b10);
        check("vc1_tx", bus.local_tx, {T_HEAD, 30'h30});
        check("vc1_owner_only", bus.req_ready, 4'b0100);

        // Write+return cancel, overflow, protocol error.
        do_reset();
        bus.req_valid = 4'b1000;
        put(3, T_SINGLE, 30'h33);
        bus.local_incr_rx_vec = 2'b01;
        #1 check("cancel_ready", bus.req_ready, 4'b1000);
        tick();
        bus.req_valid = '0;
        #1 check("cancel_no_err", bus.err_credit, 1'b0);
        check("cancel_vcw", bus.local_vc_write_tx, 2'b01);
        tick();
        bus.local_incr_rx_vec = 2'b00;
        bus.req_valid = 4'b0010;
        put(1, T_BODY, 30'h77);
        #1 check("ovf_err_credit", bus.err_credit, 1'b1);
        check("body_idle_ready", bus.req_ready, 4'b0010);
        check("body_idle_no_err_yet", bus.err_proto, 1'b0);
        tick();
        bus.req_valid = '0;
        #1 check("body_idle_dropped", bus.local_vc_write_tx, 2'b00);
        check("body_idle_err_proto", bus.err_proto, 1'b1);
        tick();
        #1 check("errs_sticky", {bus.err_credit, bus.err_proto}, 2'b11);

        // Randomized traffic.
        do_reset();
        clear_gen();
        acc = '0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                rst = 1'b0;
                bus.req_valid = '0;
                bus.local_incr_rx_vec = '0;
                clear_gen();
                tick();
                tick();
                rst = 1'b1;
            end
            for (int i = 0; i < NR; i++) begin
                if (!has[i] && ($urandom % 3 == 0)) new_pkt(i);
                bus.req_valid[i] = has[i] && ($urandom % 4 != 0);
                bus.req_flit[i*FW +: FW] = cur[i];
            end
            for (int v = 0; v < NV; v++) begin
                if (infl[v] > 0 && ($urandom % 3 == 0)) begin
                    bus.local_incr_rx_vec[v] = 1'b1;
                    infl[v]--;
                end else begin
                    bus.local_incr_rx_vec[v] = ($urandom % 500 == 0);
                end
            end
            #1 acc = bus.req_valid & bus.req_ready;
            tick();
            for (int i = 0; i < NR; i++) if (acc[i]) advance(i);
            for (int v = 0; v < NV; v++) if (bus.local_vc_write_tx[v]) infl[v]++;
        end
        bus.req_valid = '0;
        bus.local_incr_rx_vec = '0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
